// File: rtl/reg16_reader_pkg.sv
// Shared types and helpers for the 16-bit register byte reader.
package reg16_reader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    // idx=0 selects bits 7:0, idx=1 selects bits 15:8
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w, input logic idx);
        return idx ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/register_16b_byte_reader.sv
// Serializes a 16-bit word onto an 8-bit valid/ready bus as two bytes, no bubble between words.
// Optional even-parity output enabled by defining REG16_BYTE_READER_PARITY_EN.
module register_16b_byte_reader
    import reg16_reader_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              clock_enable,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy
`ifdef REG16_BYTE_READER_PARITY_EN
    ,
    output logic              byte_parity
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] hold_q;
    logic [BYTE_W-1:0] byte_q;
    logic [BYTE_W-1:0] byte_d;
    logic              accept;
    logic              emit;

    assign accept = clock_enable & word_valid & word_ready;
    assign emit   = clock_enable & byte_valid & byte_ready;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FIRST;
            FIRST:   if (emit)   state_d = SECOND;
            SECOND:  if (emit)   state_d = accept ? FIRST : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // byte_ready -> word_ready in SECOND is the only combinational path through the block
    always_comb begin
        byte_valid = (state_q == FIRST) || (state_q == SECOND);
        byte_last  = (state_q == SECOND);
        busy       = (state_q != IDLE);
        word_ready = 1'b0;
        if (state_q == IDLE) begin
            word_ready = 1'b1;
        end else if (state_q == SECOND) begin
            word_ready = byte_ready;
        end
    end

    always_comb begin
        byte_d = byte_q;
        if (accept) begin
            byte_d = byte_sel(word_in, HIGH_FIRST);
        end else if (emit && (state_q == FIRST)) begin
            byte_d = byte_sel(hold_q, ~HIGH_FIRST);
        end else if (emit) begin
            byte_d = '0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hold_q <= '0;
            byte_q <= '0;
        end else if (clock_enable) begin
            if (accept) begin
                hold_q <= word_in;
            end
            byte_q <= byte_d;
        end
    end

    assign byte_out = byte_q;

`ifdef REG16_BYTE_READER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            parity_q <= 1'b0;
        end else if (clock_enable) begin
            parity_q <= ^byte_d;
        end
    end

    assign byte_parity = parity_q;
`endif

endmodule

// File: tb/tb_register_16b_byte_reader.sv
// Bench for register_16b_byte_reader: vector table, hand sequences and a byte scoreboard.
module tb_register_16b_byte_reader;

    logic        clock = 1'b0;
    logic        clear;
    logic        clock_enable;
    logic [15:0] word_in;
    logic        word_valid;
    logic        byte_ready;

    logic        word_ready,  word_ready_hf;
    logic [7:0]  byte_out,    byte_out_hf;
    logic        byte_valid,  byte_valid_hf;
    logic        byte_last,   byte_last_hf;
    logic        busy,        busy_hf;
`ifdef REG16_BYTE_READER_PARITY_EN
    logic        byte_parity, byte_parity_hf;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    always #5 clock = ~clock;

    register_16b_byte_reader #(.HIGH_FIRST(1'b0)) dut (
        .clock(clock), .clear(clear), .clock_enable(clock_enable),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .busy(busy)
`ifdef REG16_BYTE_READER_PARITY_EN
        , .byte_parity(byte_parity)
`endif
    );

    register_16b_byte_reader #(.HIGH_FIRST(1'b1)) dut_hf (
        .clock(clock), .clear(clear), .clock_enable(clock_enable),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready_hf),
        .byte_out(byte_out_hf), .byte_valid(byte_valid_hf), .byte_ready(byte_ready),
        .byte_last(byte_last_hf), .busy(busy_hf)
`ifdef REG16_BYTE_READER_PARITY_EN
        , .byte_parity(byte_parity_hf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard on the low-first instance: pop on emit, push on accept (model bytes from word_in).
    always @(negedge clock) begin
        if (!clear && clock_enable) begin
            if (byte_valid && byte_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got byte %h, required no byte", byte_out);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check("sb_byte", {24'h0, byte_out}, {24'h0, e[7:0]});
                    check("sb_last", {31'h0, byte_last}, {31'h0, e[8]});
                end
            end
            if (word_valid && word_ready) begin
                sb.push_back({1'b0, word_in[7:0]});
                sb.push_back({1'b1, word_in[15:8]});
            end
        end
    end

    typedef struct {
        logic [15:0] word;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    task automatic run_single(input logic [15:0] w, input logic [7:0] lo, input logic [7:0] hi);
        word_in = w; word_valid = 1'b1; byte_ready = 1'b1;
        tick();
        word_valid = 1'b0;
        check("first_byte",    {24'h0, byte_out},    {24'h0, lo});
        check("first_valid",   {31'h0, byte_valid},  32'd1);
        check("first_last",    {31'h0, byte_last},   32'd0);
        check("first_wready",  {31'h0, word_ready},  32'd0);
        check("hf_first_byte", {24'h0, byte_out_hf}, {24'h0, hi});
        check("hf_first_last", {31'h0, byte_last_hf}, 32'd0);
        tick();
        check("second_byte",    {24'h0, byte_out},    {24'h0, hi});
        check("second_last",    {31'h0, byte_last},   32'd1);
        check("hf_second_byte", {24'h0, byte_out_hf}, {24'h0, lo});
        check("hf_second_last", {31'h0, byte_last_hf}, 32'd1);
        tick();
        check("done_valid", {31'h0, byte_valid}, 32'd0);
        check("done_busy",  {31'h0, busy},       32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{16'hA55A, 8'h5A, 8'hA5};
        vecs[1] = '{16'hC3A1, 8'hA1, 8'hC3};
        vecs[2] = '{16'h8001, 8'h01, 8'h80};
        vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF};

        clear = 1'b1; clock_enable = 1'b1; word_in = '0; word_valid = 1'b0; byte_ready = 1'b0;
        #12;
        check("rst_byte",  {24'h0, byte_out},   32'h0);
        check("rst_valid", {31'h0, byte_valid}, 32'd0);
        check("rst_last",  {31'h0, byte_last},  32'd0);
        check("rst_busy",  {31'h0, busy},       32'd0);
        tick();
        clear = 1'b0;
        tick();
        check("rst_wready", {31'h0, word_ready}, 32'd1);

        for (int i = 0; i < 4; i++) run_single(vecs[i].word, vecs[i].lo, vecs[i].hi);

        // Back-to-back words, word_valid held high
        word_in = 16'h1234; word_valid = 1'b1; byte_ready = 1'b1;
        tick();
        word_in = 16'hBEEF;
        check("b2b_34", {24'h0, byte_out}, 32'h34);
        check("b2b_34_last", {31'h0, byte_last}, 32'd0);
        tick();
        check("b2b_12", {24'h0, byte_out}, 32'h12);
        check("b2b_12_last", {31'h0, byte_last}, 32'd1);
        check("b2b_12_wready", {31'h0, word_ready}, 32'd1);
        tick();
        word_valid = 1'b0;
        check("b2b_EF", {24'h0, byte_out}, 32'hEF);
        check("b2b_EF_last", {31'h0, byte_last}, 32'd0);
        check("b2b_EF_valid", {31'h0, byte_valid}, 32'd1);
        tick();
        check("b2b_BE", {24'h0, byte_out}, 32'hBE);
        check("b2b_BE_last", {31'h0, byte_last}, 32'd1);
        tick();
        check("b2b_idle", {31'h0, byte_valid}, 32'd0);

        // Backpressure with a competing word that must be refused
        word_in = 16'h00FF; word_valid = 1'b1; byte_ready = 1'b0;
        tick();
        word_in = 16'h7777;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin byte_ready = 1'b1; word_valid = 1'b0; end
            check("bp_byte",   {24'h0, byte_out},   32'hFF);
            check("bp_valid",  {31'h0, byte_valid}, 32'd1);
            check("bp_wready", {31'h0, word_ready}, 32'd0);
            tick();
        end
        check("bp_second", {24'h0, byte_out}, 32'h00);
        check("bp_second_last", {31'h0, byte_last}, 32'd1);
        tick();
        check("bp_idle", {31'h0, byte_valid}, 32'd0);

        // Clear asserted mid-word in SECOND
        word_in = 16'hDEAD; word_valid = 1'b1; byte_ready = 1'b1;
        tick();
        word_valid = 1'b0;
        tick();
        check("mr_second", {24'h0, byte_out}, 32'hDE);
        clear = 1'b1;
        #1;
        check("mr_valid", {31'h0, byte_valid}, 32'd0);
        check("mr_busy",  {31'h0, busy},       32'd0);
        check("mr_byte",  {24'h0, byte_out},   32'h00);
        check("mr_last",  {31'h0, byte_last},  32'd0);
        sb.delete();
        tick();
        clear = 1'b0;
        tick();
        check("mr_wready", {31'h0, word_ready}, 32'd1);
        run_single(16'h0102, 8'h02, 8'h01);

        // clock_enable low for two cycles during FIRST
        word_in = 16'h0307; word_valid = 1'b1; byte_ready = 1'b1;
        tick();
        word_valid = 1'b0; clock_enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("ce_byte",  {24'h0, byte_out},   32'h07);
            check("ce_valid", {31'h0, byte_valid}, 32'd1);
            check("ce_last",  {31'h0, byte_last},  32'd0);
`ifdef REG16_BYTE_READER_PARITY_EN
            check("ce_parity_07", {31'h0, byte_parity}, 32'd1);
`endif
        end
        clock_enable = 1'b1;
        tick();
        check("ce_resume", {24'h0, byte_out}, 32'h03);
        check("ce_resume_last", {31'h0, byte_last}, 32'd1);
`ifdef REG16_BYTE_READER_PARITY_EN
        check("ce_parity_03", {31'h0, byte_parity}, 32'd0);
`endif
        tick();
        check("ce_idle", {31'h0, busy}, 32'd0);
        tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
